// File: rtl/uart_pkg.sv
// Shared definitions for apb_uart_fifo: register offsets (word index PADDR[4:2]),
// STATUS/CTRL bit positions and the TX/RX state encodings.
package uart_pkg;
  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_RXDATA = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_DIV    = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_FRM_ERR  = 4;
  localparam int ST_OVERRUN  = 5;
  localparam int ST_PAR_ERR  = 6;

  localparam int CT_TX_EN    = 0;
  localparam int CT_RX_EN    = 1;
  localparam int CT_IE_RXNE  = 2;
  localparam int CT_IE_TXE   = 3;
  localparam int CT_IE_ERR   = 4;
  localparam int CT_PAR_EN   = 5;
  localparam int CT_PAR_ODD  = 6;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead output (dout is the head entry).
// Ports: gclk, grst_n (sync, active low), push/din, pop, dout, full, empty.
// A push while full is accepted only together with a pop; a pop while empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge gclk)
    if (do_push) mem[wr_ptr] <= din;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/apb_uart_fifo.sv
// APB3 UART with TX/RX FIFOs, programmable baud divisor and level interrupt.
// Ports: PCLK, PRESETn (sync, active low), APB slave (PSELx, PENABLE, PWRITE, PADDR,
// PWDATA, PRDATA, PREADY, PSLVERR), serial RX (async) / Tx (idle high), irq.
// Optional feature macro: UART_PARITY_EN adds a parity bit (CTRL[5]=enable, CTRL[6]=odd).
module apb_uart_fifo
  import uart_pkg::*;
#(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RST    = 16'd26
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        RX,
  output logic        Tx,
  output logic        irq
);
`ifdef UART_PARITY_EN
  localparam logic [6:0] CTRL_MASK = 7'h7F;
`else
  localparam logic [6:0] CTRL_MASK = 7'h1F;
`endif

  logic [15:0] div_q, baud_cnt;
  logic [6:0]  ctrl, status;
  logic        tick, frame_err, overrun, parity_err;
  logic [2:0]  addr;
  logic        setup, access, wr_acc, rd_acc;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] tx_dout, rx_dout;
  logic        unused_bits;

  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

  assign addr   = PADDR[4:2];
  assign setup  = PSELx & ~PENABLE;
  assign access = PSELx & PENABLE & ~PSLVERR;  // errored transfers change nothing
  assign wr_acc = access & PWRITE;
  assign rd_acc = access & ~PWRITE;
  assign PREADY = PSELx & PENABLE;
  assign status = {parity_err, overrun, frame_err, rx_empty, rx_full, tx_empty, tx_full};
  assign irq    = (ctrl[CT_IE_RXNE] & ~rx_empty) | (ctrl[CT_IE_TXE] & tx_empty) |
                  (ctrl[CT_IE_ERR] & (frame_err | overrun | parity_err));

  // Response is decided in the setup phase so it is registered and stable by the
  // access phase; the side effect (push/pop/write) happens on the access edge.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (addr)
      OFF_TXDATA: rd_err = PWRITE & tx_full;
      OFF_RXDATA: begin
        rd_err = PWRITE | rx_empty;
        if (!rd_err) rd_data = 32'(rx_dout);
      end
      OFF_STATUS: rd_data = 32'(status);
      OFF_DIV:    rd_data = 32'(div_q);
      OFF_CTRL:   rd_data = 32'(ctrl);
      default:    rd_err  = 1'b1;
    endcase
    if (PWRITE) rd_data = '0;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
    end else if (setup) begin
      PRDATA  <= rd_data;
      PSLVERR <= rd_err;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      div_q <= DIV_RST;
      ctrl  <= '0;
    end else if (wr_acc) begin
      if (addr == OFF_DIV)  div_q <= PWDATA[15:0];
      if (addr == OFF_CTRL) ctrl  <= PWDATA[6:0] & CTRL_MASK;
    end
  end

  // Oversample tick: one pulse every div_q+1 cycles; a DIV write restarts the count.
  assign tick = (baud_cnt == '0);
  always_ff @(posedge PCLK) begin
    if (!PRESETn)                        baud_cnt <= DIV_RST;
    else if (wr_acc && addr == OFF_DIV)  baud_cnt <= PWDATA[15:0];
    else if (tick)                       baud_cnt <= div_q;
    else                                 baud_cnt <= baud_cnt - 1'b1;
  end

  assign tx_push = wr_acc & (addr == OFF_TXDATA);
  assign rx_pop  = rd_acc & (addr == OFF_RXDATA);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .gclk(PCLK), .grst_n(PRESETn), .push(tx_push), .din(PWDATA[DATA_BITS-1:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty));

  // ---------------- transmitter ----------------
  tx_state_e            tx_st;
  logic [3:0]           tx_tk;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_go, tx_last_tk;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_go      = ctrl[CT_TX_EN] & ~tx_empty;
  assign tx_last_tk = tick & (tx_tk == 4'd15);
  // frames chain straight from STOP into the next START when data is waiting
  assign tx_pop     = tx_go & ((tx_st == TX_IDLE) | ((tx_st == TX_STOP) & tx_last_tk));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_st  <= TX_IDLE;
      tx_tk  <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
`ifdef UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_st  <= TX_START;
      tx_tk  <= '0;
      tx_sh  <= tx_dout;
`ifdef UART_PARITY_EN
      tx_par <= ^tx_dout ^ ctrl[CT_PAR_ODD];
`endif
    end else if (tx_st != TX_IDLE && tick) begin
      tx_tk <= tx_tk + 1'b1;
      if (tx_tk == 4'd15) begin
        case (tx_st)
          TX_START: begin
            tx_st  <= TX_DATA;
            tx_bit <= '0;
          end
          TX_DATA: begin
            tx_sh  <= tx_sh >> 1;
            tx_bit <= tx_bit + 1'b1;
`ifdef UART_PARITY_EN
            if (tx_bit == 3'(DATA_BITS-1)) tx_st <= ctrl[CT_PAR_EN] ? TX_PARITY : TX_STOP;
`else
            if (tx_bit == 3'(DATA_BITS-1)) tx_st <= TX_STOP;
`endif
          end
          TX_PARITY: tx_st <= TX_STOP;
          default:   tx_st <= TX_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (tx_st)
      TX_START:  Tx = 1'b0;
      TX_DATA:   Tx = tx_sh[0];
`ifdef UART_PARITY_EN
      TX_PARITY: Tx = tx_par;
`endif
      default:   Tx = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e            rx_st;
  logic                 rx_m, rx_s, rx_d;
  logic [3:0]           rx_tk;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_mid, rx_stop_mid, ferr_set, ovr_set, perr_set;

  assign rx_mid      = tick & (rx_tk == 4'd15);
  assign rx_stop_mid = (rx_st == RX_STOP) & rx_mid;
  assign ferr_set    = rx_stop_mid & ~rx_s;
  assign rx_push     = rx_stop_mid & rx_s & (~rx_full | rx_pop);
  assign ovr_set     = rx_stop_mid & rx_s & rx_full & ~rx_pop;
`ifdef UART_PARITY_EN
  assign perr_set    = (rx_st == RX_PARITY) & rx_mid & (rx_s != (^rx_sh ^ ctrl[CT_PAR_ODD]));
`else
  assign perr_set    = 1'b0;
`endif

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .gclk(PCLK), .grst_n(PRESETn), .push(rx_push), .din(rx_sh),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // START counts 8 ticks to mid start bit; afterwards every 16th tick is mid-bit.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rx_st  <= RX_IDLE;
      rx_tk  <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      case (rx_st)
        RX_IDLE: if (ctrl[CT_RX_EN] && rx_d && !rx_s) begin
          rx_st <= RX_START;
          rx_tk <= '0;
        end
        RX_START: if (tick) begin
          rx_tk <= rx_tk + 1'b1;
          if (rx_tk == 4'd7) begin
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
            rx_tk  <= '0;
            rx_bit <= '0;
          end
        end
        RX_DATA: if (tick) begin
          rx_tk <= rx_tk + 1'b1;
          if (rx_tk == 4'd15) begin
            rx_sh  <= {rx_s, rx_sh[DATA_BITS-1:1]};
            rx_bit <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
            if (rx_bit == 3'(DATA_BITS-1)) rx_st <= ctrl[CT_PAR_EN] ? RX_PARITY : RX_STOP;
`else
            if (rx_bit == 3'(DATA_BITS-1)) rx_st <= RX_STOP;
`endif
          end
        end
        RX_PARITY: if (tick) begin
          rx_tk <= rx_tk + 1'b1;
          if (rx_tk == 4'd15) rx_st <= RX_STOP;
        end
        default: if (tick) begin
          rx_tk <= rx_tk + 1'b1;
          if (rx_tk == 4'd15) rx_st <= RX_IDLE;
        end
      endcase
    end
  end

  // sticky errors: W1C clear, a same-cycle set wins
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (wr_acc && addr == OFF_STATUS) begin
        if (PWDATA[ST_FRM_ERR]) frame_err  <= 1'b0;
        if (PWDATA[ST_OVERRUN]) overrun    <= 1'b0;
        if (PWDATA[ST_PAR_ERR]) parity_err <= 1'b0;
      end
      if (ferr_set) frame_err  <= 1'b1;
      if (ovr_set)  overrun    <= 1'b1;
      if (perr_set) parity_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_apb_uart_fifo.sv
module tb_apb_uart_fifo;
  logic        PCLK = 1'b0, PRESETn = 1'b0;
  logic        PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        RX = 1'b1;
  logic        Tx, irq;

  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  apb_uart_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_RST(16'd26)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .RX(RX), .Tx(Tx), .irq(irq));

  always #5 PCLK = ~PCLK;

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(negedge PCLK);
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 begin d = PRDATA; err = PSLVERR; end
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  // Decode one frame from Tx at 16 PCLK per bit, sampling mid-bit.
  task automatic decode_tx(output logic [7:0] b, output logic stop, output logic ok);
    ok = 1'b0; b = '0; stop = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge PCLK);
      if (Tx === 1'b0) begin ok = 1'b1; break; end
    end
    if (ok) begin
      repeat (8) @(negedge PCLK);
      if (Tx !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (16) @(negedge PCLK);
        b[k] = Tx;
      end
      repeat (16) @(negedge PCLK);
      stop = Tx;
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    @(negedge PCLK);
    RX = 1'b0;
    repeat (16) @(negedge PCLK);
    for (int k = 0; k < 8; k++) begin
      RX = b[k];
      repeat (16) @(negedge PCLK);
    end
    RX = stop;
    repeat (16) @(negedge PCLK);
    RX = 1'b1;
    repeat (20) @(negedge PCLK);
  endtask

  task automatic test_reset;
    logic [31:0] d; logic e;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    total_cnt++;
    if ({PRDATA, PREADY, PSLVERR, Tx, irq} !== {32'h0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL reset_outputs: got PRDATA=%h PREADY=%b PSLVERR=%b Tx=%b irq=%b, want 0 0 0 1 0",
               PRDATA, PREADY, PSLVERR, Tx, irq);
    else pass_cnt++;
    PRESETn = 1'b1;
    apb_read(32'h08, d, e);
    total_cnt++;
    if (d !== 32'h0A || e !== 1'b0) $display("FAIL reset_status: got %h err %b, want 0000000a err 0", d, e);
    else pass_cnt++;
    apb_read(32'h0C, d, e);
    total_cnt++;
    if (d !== 32'd26) $display("FAIL reset_div: got %0d, want 26", d);
    else pass_cnt++;
    apb_read(32'h10, d, e);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL reset_ctrl: got %h, want 0", d);
    else pass_cnt++;
  endtask

  task automatic test_tx_55;
    logic e, stop, ok; logic [7:0] b, exp;
    apb_write(32'h0C, 32'h0, e);
    apb_write(32'h10, 32'h1, e);
    tx_q.push_back(8'h55);
    apb_write(32'h00, 32'h55, e);
    decode_tx(b, stop, ok);
    exp = tx_q.pop_front();
    total_cnt++;
    if (!ok || b !== exp) $display("FAIL tx_55_data: got %h ok %b, want %h", b, ok, exp);
    else pass_cnt++;
    total_cnt++;
    if (stop !== 1'b1) $display("FAIL tx_55_stop: got %b, want 1", stop);
    else pass_cnt++;
  endtask

  task automatic test_tx_fill;
    logic e, stop, ok, all_ok; logic [7:0] b, exp; logic [31:0] d;
    repeat (40) @(negedge PCLK);
    apb_write(32'h10, 32'h0, e);
    all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'(i * 37 + 11);
      tx_q.push_back(b);
      apb_write(32'h00, {24'h0, b}, e);
      if (e !== 1'b0) all_ok = 1'b0;
    end
    total_cnt++;
    if (!all_ok) $display("FAIL fill_no_err: got an error on writes 1..16, want none");
    else pass_cnt++;
    apb_write(32'h00, 32'hEE, e);
    total_cnt++;
    if (e !== 1'b1) $display("FAIL fill_17th_pslverr: got %b, want 1", e);
    else pass_cnt++;
    apb_read(32'h08, d, e);
    total_cnt++;
    if (d[0] !== 1'b1 || d[1] !== 1'b0) $display("FAIL fill_tx_full: got status %h, want tx_full=1 tx_empty=0", d);
    else pass_cnt++;
    apb_write(32'h10, 32'h1, e);
    for (int i = 0; i < 16; i++) begin
      decode_tx(b, stop, ok);
      exp = tx_q.pop_front();
      total_cnt++;
      if (!ok || b !== exp || stop !== 1'b1)
        $display("FAIL fill_frame%0d: got %h stop %b ok %b, want %h stop 1", i, b, stop, ok, exp);
      else pass_cnt++;
    end
    repeat (20) @(negedge PCLK);
    total_cnt++;
    if (Tx !== 1'b1) $display("FAIL fill_no_17th: got Tx=%b after 16 frames, want idle 1", Tx);
    else pass_cnt++;
  endtask

  task automatic test_rx;
    logic e; logic [31:0] d; logic [7:0] exp;
    apb_write(32'h10, 32'h06, e);
    rx_q.push_back(8'hA3);
    drive_rx(8'hA3, 1'b1);
    apb_read(32'h08, d, e);
    total_cnt++;
    if (d[3] !== 1'b0) $display("FAIL rx_nempty: got status %h, want rx_empty=0", d);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL rx_irq: got %b, want 1", irq);
    else pass_cnt++;
    apb_read(32'h04, d, e);
    exp = rx_q.pop_front();
    total_cnt++;
    if (d !== {24'h0, exp} || e !== 1'b0) $display("FAIL rx_data: got %h err %b, want %h err 0", d, e, {24'h0, exp});
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b0) $display("FAIL rx_irq_clear: got %b, want 0", irq);
    else pass_cnt++;
  endtask

  task automatic test_frame_err;
    logic e; logic [31:0] d;
    apb_write(32'h10, 32'h12, e);
    drive_rx(8'h5A, 1'b0);
    apb_read(32'h08, d, e);
    total_cnt++;
    if (d[4] !== 1'b1 || d[3] !== 1'b1) $display("FAIL ferr_set: got status %h, want frame_err=1 rx_empty=1", d);
    else pass_cnt++;
    total_cnt++;
    if (irq !== 1'b1) $display("FAIL ferr_irq: got %b, want 1", irq);
    else pass_cnt++;
    apb_write(32'h08, 32'h10, e);
    apb_read(32'h08, d, e);
    total_cnt++;
    if (d[4] !== 1'b0 || irq !== 1'b0) $display("FAIL ferr_w1c: got status %h irq %b, want frame_err=0 irq 0", d, irq);
    else pass_cnt++;
  endtask

  task automatic test_errors;
    logic e; logic [31:0] d;
    apb_read(32'h04, d, e);
    total_cnt++;
    if (e !== 1'b1 || d !== 32'h0) $display("FAIL rxdata_empty: got %h err %b, want 0 err 1", d, e);
    else pass_cnt++;
    apb_read(32'h14, d, e);
    total_cnt++;
    if (e !== 1'b1) $display("FAIL unmapped_read: got err %b, want 1", e);
    else pass_cnt++;
    apb_write(32'h04, 32'h12, e);
    total_cnt++;
    if (e !== 1'b1) $display("FAIL rxdata_write: got err %b, want 1", e);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_tx;
    logic e, ok; logic [31:0] d;
    apb_write(32'h10, 32'h1, e);
    apb_write(32'h00, 32'h08, e);
    apb_write(32'h00, 32'h77, e);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge PCLK);
      if (Tx === 1'b0) begin ok = 1'b1; break; end
    end
    repeat (8 + 16 * 4) @(negedge PCLK);
    total_cnt++;
    if (!ok || Tx !== 1'b1) $display("FAIL midtx_bit3: got Tx=%b ok %b, want bit3 of 0x08 = 1", Tx, ok);
    else pass_cnt++;
    PRESETn = 1'b0;
    @(posedge PCLK);
    #1;
    total_cnt++;
    if (Tx !== 1'b1) $display("FAIL midtx_reset_tx: got %b, want 1", Tx);
    else pass_cnt++;
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_read(32'h08, d, e);
    total_cnt++;
    if (d[1] !== 1'b1) $display("FAIL midtx_tx_empty: got status %h, want tx_empty=1", d);
    else pass_cnt++;
    apb_read(32'h0C, d, e);
    total_cnt++;
    if (d !== 32'd26) $display("FAIL midtx_div: got %0d, want 26", d);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_tx_55;
    test_tx_fill;
    test_rx;
    test_frame_err;
    test_errors;
    test_reset_mid_tx;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish within 2ms");
    $fatal(1);
  end
endmodule
